// File: rtl/uart_tx_engine.sv
// uart_tx_engine: 11-bit-time UART frame serializer with runtime data/parity/baud configuration.
module uart_tx_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [7:0]  din,
  input  logic        eight,
  input  logic        pen,
  input  logic        ohel,
  input  logic [18:0] baud_k,
  output logic        tx,
  output logic        txrdy,
  output logic        tx_done
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t      r_state, w_state_nxt;
  logic [9:0]  r_shift, w_shift_nxt;
  logic [3:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [18:0] r_baud_k, w_baud_k_nxt, r_baud_cnt, w_baud_cnt_nxt, w_k;
  logic        r_tx, w_tx_nxt, r_txrdy, w_txrdy_nxt, r_done, w_done_nxt;
  logic        w_par, w_bit8, w_bit9;
  assign w_k    = (baud_k == '0) ? 19'd1 : baud_k;
  assign w_par  = (eight ? ^din : ^din[6:0]) ^ ohel;
  assign w_bit8 = eight ? din[7] : (pen ? w_par : 1'b1);
  assign w_bit9 = (eight && pen) ? w_par : 1'b1;
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_baud_k_nxt   = r_baud_k;
    w_baud_cnt_nxt = r_baud_cnt;
    w_tx_nxt       = r_tx;
    w_txrdy_nxt    = r_txrdy;
    w_done_nxt     = 1'b0;
    if (r_state == IDLE) begin
      if (r_txrdy && load) begin
        w_state_nxt    = SHIFT;
        w_shift_nxt    = {1'b1, w_bit9, w_bit8, din[6:0]};
        w_bit_cnt_nxt  = '0;
        w_baud_k_nxt   = w_k;
        w_baud_cnt_nxt = w_k - 19'd1;
        w_tx_nxt       = 1'b0;
        w_txrdy_nxt    = 1'b0;
      end
    end else if (r_baud_cnt != '0) begin
      w_baud_cnt_nxt = r_baud_cnt - 19'd1;
    end else if (r_bit_cnt == 4'd10) begin
      w_state_nxt = IDLE;
      w_tx_nxt    = 1'b1;
      w_txrdy_nxt = 1'b1;
      w_done_nxt  = 1'b1;
    end else begin
      // Bit boundary: present the next frame bit and restart the bit timer.
      w_bit_cnt_nxt  = r_bit_cnt + 4'd1;
      w_tx_nxt       = r_shift[0];
      w_shift_nxt    = {1'b1, r_shift[9:1]};
      w_baud_cnt_nxt = r_baud_k - 19'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_shift    <= '1;
      r_bit_cnt  <= '0;
      r_baud_k   <= '0;
      r_baud_cnt <= '0;
      r_tx       <= 1'b1;
      r_txrdy    <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_baud_k   <= w_baud_k_nxt;
      r_baud_cnt <= w_baud_cnt_nxt;
      r_tx       <= w_tx_nxt;
      r_txrdy    <= w_txrdy_nxt;
      r_done     <= w_done_nxt;
    end
  end
  assign tx      = r_tx;
  assign txrdy   = r_txrdy;
  assign tx_done = r_done;
endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 Parameters: none; all frame configuration is supplied on ports.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low (0 = reset, sampled on rising clk).
REQ-004 load  input  1  one-cycle write strobe from the processor port decode; requests transmission of din.
REQ-005 din  input  8  byte to transmit, LSB first.
REQ-006 eight  input  1  1 = 8 data bits, 0 = 7 data bits (din[7] ignored).
REQ-007 pen  input  1  parity enable.
REQ-008 ohel  input  1  parity sense when pen=1: 0 = even, 1 = odd.
REQ-009 baud_k  input  19  bit time in clk cycles; value 0 is treated as 1.
REQ-010 tx  output  1  serial line, idle high.
REQ-011 txrdy  output  1  status flag: 1 = ready to accept load.
REQ-012 tx_done  output  1  one-cycle pulse at end of frame.

Function
REQ-013 The block SHALL have two states, IDLE and SHIFT.
REQ-014 In IDLE with txrdy=1, load=1 SHALL, on that edge, capture din, eight, pen, ohel and baud_k, clear txrdy, drive tx=0 (start bit), and enter SHIFT.
REQ-015 A load asserted while txrdy=0 (including the tx_done cycle) SHALL be ignored, with no effect on the frame in progress.
REQ-016 Every frame SHALL be exactly 11 bit times: bit0 is the start bit (0), bits1-7 are d0..d6, bit8 through bit10 are given by REQ-017 to REQ-019.
REQ-017 Bit8 SHALL be d7 if eight=1; otherwise it is the parity bit if pen=1, else 1.
REQ-018 Bit9 SHALL be the parity bit if eight=1 and pen=1; otherwise 1.
REQ-019 Bit10 SHALL be 1.
REQ-020 Parity SHALL be computed over the transmitted data bits only (7 or 8): even gives an XOR reduction; odd gives its inverse.
REQ-021 Each bit SHALL be held on tx for exactly max(baud_k,1) clk cycles, timed by a down-counter reloaded from the captured value.
REQ-022 Changes to din or the config inputs during SHIFT SHALL NOT affect the frame in progress.
REQ-023 tx SHALL be a registered output with no glitches, changing only at bit boundaries.
REQ-024 At the end of bit10, the same edge SHALL return to IDLE, keep tx=1, set txrdy=1, and assert tx_done for exactly one cycle.
REQ-025 txrdy SHALL behave as a set/reset flag with reset priority: rst forces 1, load-accept clears it, end-of-frame sets it.
REQ-026 Total txrdy-low time SHALL be 11*max(baud_k,1) cycles, measured from the load edge to the set edge.
REQ-027 A new load is accepted on the first cycle after the txrdy rising edge, with a back-to-back start bit and no idle gap beyond that cycle.

Reset
REQ-028 When rst=0 at a rising edge, the block SHALL set tx=1, txrdy=1, tx_done=0 and state=IDLE, and clear the bit and baud counters.
REQ-029 Reset SHALL take effect at any time, including mid-frame: the frame is aborted and tx is high from that edge.
REQ-030 The first load SHALL be accepted on the first edge with rst=1.

Verification
REQ-031 baud_k=4, eight=1, pen=0, load din=0x55 -> tx = 0,1,0,1,0,1,0,1,0,1,1, each held 4 cycles; txrdy low 44 cycles; tx_done pulses once.
REQ-032 baud_k=2, eight=1, pen=1, ohel=0, din=0x03 -> bit9 (parity) = 0, bit10 = 1; with ohel=1, bit9 = 1.
REQ-033 baud_k=3, eight=0, pen=1, ohel=1, din=0xC1 -> bits1-7 = 1,0,0,0,0,0,1, bit8 = 1 (odd parity), din[7] ignored.
REQ-034 Assert load again 10 cycles into a frame with din=0xFF -> ignored; the original frame completes unchanged. Assert load on the cycle after txrdy rises -> a new start bit begins immediately.
REQ-035 rst=0 mid-frame (bit 5) -> next edge gives tx=1, txrdy=1, no tx_done; a subsequent load sends a complete, correct frame.
REQ-036 baud_k=0, din=0x00, eight=1, pen=0 -> frame lasts 11 cycles with one cycle per bit.
